// File: rtl/axis_mem_writer.sv
`default_nettype none
// ============================================================================
// Module   : axis_mem_writer
// Purpose  : Loads the register-block parameter memory from a 32-bit
//            AXI-Stream. Each packet is a run of blocks, and each block is one
//            address word (the block index) followed by NREG register words.
//            Every register word is scattered into a 256-bit, byte-enabled
//            memory row: block b / register j lands in row {b[14:0], j[3]},
//            32-bit lane j[2:0].
//
// Parameters:
//   NB    - number of register blocks (1..32); higher block indices are
//           consumed but never written
//   NREG  - register words per block (1..16)
//
// Ports:
//   clk            in   1    rising-edge clock
//   rstn           in   1    asynchronous active-low reset
//   s_axis_tvalid  in   1    stream beat valid
//   s_axis_tready  out  1    stream ready (combinational from state, START_REG)
//   s_axis_tdata   in   32   address word or register word
//   s_axis_tlast   in   1    final beat of the load
//   mem_addr       out  16   memory row address
//   mem_din        out  256  write data (word replicated into all 8 lanes)
//   mem_we         out  32   byte write enables, lane k = bits [4k+3:4k]
//   START_REG      in   1    level arm/enable from the register map
//
// Revision : 1.0 - initial release
// ============================================================================
module axis_mem_writer #(
  parameter int NB   = 16,
  parameter int NREG = 12
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         s_axis_tvalid,
  output logic         s_axis_tready,
  input  logic [31:0]  s_axis_tdata,
  input  logic         s_axis_tlast,
  output logic [15:0]  mem_addr,
  output logic [255:0] mem_din,
  output logic [31:0]  mem_we,
  input  logic         START_REG
);

  // --------------------------------------------------------------------------
  // State encoding
  // --------------------------------------------------------------------------
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Index of the final register word in a block.
  localparam logic [3:0]  C_J_LAST = 4'(NREG - 1);
  // Block count widened to the 16-bit comparison width used below.
  localparam logic [15:0] C_NB     = 16'(NB);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [1:0]   state_q,    state_d;
  logic [14:0]  blk_q,      blk_d;
  logic [3:0]   j_q,        j_d;
  logic [15:0]  mem_addr_q, mem_addr_d;
  logic [255:0] mem_din_q,  mem_din_d;
  logic [31:0]  mem_we_q,   mem_we_d;

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic        w_tready;
  logic        w_accept;
  logic        w_addr_beat;
  logic        w_data_beat;
  logic        w_blk_in_range;
  logic [15:0] w_row;
  logic [31:0] w_lane_we;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // Dropping START_REG in ADDR/DATA aborts straight back to IDLE; tready is
  // already low in that cycle, so the beat on the bus is never consumed.
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (START_REG) begin
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (!START_REG) begin
          state_d = S_IDLE;
        end else if (w_accept) begin
          state_d = s_axis_tlast ? S_DONE : S_DATA;
        end
      end
      S_DATA: begin
        if (!START_REG) begin
          state_d = S_IDLE;
        end else if (w_accept) begin
          if (s_axis_tlast) begin
            state_d = S_DONE;
          end else if (j_q == C_J_LAST) begin
            state_d = S_ADDR;
          end
        end
      end
      S_DONE: begin
        // Holding START_REG high keeps us here; a new load needs a fresh arm.
        if (!START_REG) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_tready    = START_REG && ((state_q == S_ADDR) || (state_q == S_DATA));
    w_accept    = w_tready && s_axis_tvalid;
    w_addr_beat = w_accept && (state_q == S_ADDR);
    w_data_beat = w_accept && (state_q == S_DATA);
  end

  assign s_axis_tready = w_tready;

  // --------------------------------------------------------------------------
  // Write address / lane decode for the current (blk, j)
  // --------------------------------------------------------------------------
  always_comb begin
    w_blk_in_range = ({1'b0, blk_q} < C_NB);
    w_row          = {blk_q, j_q[3]};
    w_lane_we      = 32'h0000_000F << {j_q[2:0], 2'b00};
  end

  // --------------------------------------------------------------------------
  // Datapath next-state
  // mem_we is a one-cycle pulse; address and data only move when a write is
  // actually issued so they hold their last values between writes.
  // --------------------------------------------------------------------------
  always_comb begin
    blk_d      = blk_q;
    j_d        = j_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_we_d   = '0;

    if (state_q == S_IDLE) begin
      j_d = '0;
    end

    if (w_addr_beat) begin
      blk_d = s_axis_tdata[14:0];
      j_d   = '0;
    end

    if (w_data_beat) begin
      // Wraps harmlessly at NREG=16: the FSM returns to ADDR, which reloads j.
      j_d = j_q + 4'd1;
      if (w_blk_in_range) begin
        mem_addr_d = w_row;
        mem_din_d  = {8{s_axis_tdata}};
        mem_we_d   = w_lane_we;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // The asynchronous clear of mem_we guarantees no write escapes once rstn
  // falls, even if a beat was in flight.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      blk_q      <= '0;
      j_q        <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_we_q   <= '0;
    end else begin
      blk_q      <= blk_d;
      j_q        <= j_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_we_q   <= mem_we_d;
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign mem_we   = mem_we_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_mem_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_mem_writer
// Purpose  : Self-checking bench for axis_mem_writer. Stimulus is a table of
//            beat records (inputs plus expected tready / expected write);
//            expected writes go to a scoreboard queue when the beat is driven
//            and are compared when mem_we fires. Reset cases are hand-written.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_mem_writer;

  localparam int NB   = 16;
  localparam int NREG = 12;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         tvalid = 1'b0;
  logic         tready;
  logic [31:0]  tdata = '0;
  logic         tlast = 1'b0;
  logic         start = 1'b0;
  logic [15:0]  mem_addr;
  logic [255:0] mem_din;
  logic [31:0]  mem_we;

  always #5 clk = ~clk;

  axis_mem_writer #(.NB(NB), .NREG(NREG)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .s_axis_tvalid(tvalid),
    .s_axis_tready(tready),
    .s_axis_tdata (tdata),
    .s_axis_tlast (tlast),
    .mem_addr     (mem_addr),
    .mem_din      (mem_din),
    .mem_we       (mem_we),
    .START_REG    (start)
  );

  typedef struct {
    logic [15:0]  addr;
    logic [31:0]  we;
    logic [255:0] din;
  } wr_t;

  typedef struct {
    bit          start;
    bit          valid;
    logic [31:0] data;
    bit          last;
    bit          exp_ready;
    bit          exp_wr;
    int          blk;
    int          rix;
  } vec_t;

  wr_t  sb[$];
  vec_t vecs[$];
  wr_t  mon_e;
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference mapping of (block, register) to memory row / lane.
  function automatic wr_t exp_write(input int b, input int j, input logic [31:0] w);
    wr_t e;
    e.addr = 16'(b * 2 + j / 8);
    e.we   = 32'h0000_000F << (4 * (j % 8));
    e.din  = {8{w}};
    return e;
  endfunction

  task automatic add(input bit s, input bit v, input logic [31:0] d, input bit l,
                     input bit r, input bit w, input int b, input int j);
    vec_t x;
    x.start = s; x.valid = v; x.data = d; x.last = l;
    x.exp_ready = r; x.exp_wr = w; x.blk = b; x.rix = j;
    vecs.push_back(x);
  endtask

  // Write monitor: every mem_we pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    if (mem_we !== '0) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: mem_we=%h mem_addr=%h required no write", mem_we, mem_addr);
      end else begin
        mon_e = sb.pop_front();
        check("wr_addr", 256'(mem_addr), 256'(mon_e.addr));
        check("wr_we",   256'(mem_we),   256'(mon_e.we));
        check("wr_din",  mem_din,        mon_e.din);
      end
    end
  end

  task automatic run_vecs(input string tag);
    foreach (vecs[i]) begin
      @(negedge clk);
      start  = vecs[i].start;
      tvalid = vecs[i].valid;
      tdata  = vecs[i].data;
      tlast  = vecs[i].last;
      #1;
      check({tag, "_tready"}, 256'(tready), 256'(vecs[i].exp_ready));
      if (vecs[i].exp_wr) sb.push_back(exp_write(vecs[i].blk, vecs[i].rix, vecs[i].data));
    end
    vecs.delete();
  endtask

  task automatic drain(input string tag);
    start = 1'b0; tvalid = 1'b0; tlast = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check({tag, "_sb_empty"}, 256'(sb.size()), 256'(0));
    sb.delete();
  endtask

  // A full NREG-word block, optionally with a bubble after every beat.
  task automatic add_block(input int b, input int base, input bit wr, input bit bp, input bit last_blk);
    add(1, 1, 32'(b), 0, 1, 0, 0, 0);
    if (bp) add(1, 0, 32'hDEAD_BEEF, 0, 1, 0, 0, 0);
    for (int j = 0; j < NREG; j++) begin
      add(1, 1, 32'(base + j), last_blk && (j == NREG - 1), 1, wr, b, j);
      if (bp && !(last_blk && (j == NREG - 1))) add(1, 0, 32'hDEAD_BEEF, 1, 1, 0, 0, 0);
    end
  endtask

  task automatic full_load(input string tag, input bit bp);
    add(1, 0, 0, 0, 0, 0, 0, 0);                 // IDLE -> ADDR, not ready yet
    for (int b = 0; b < NB; b++) add_block(b, 12 * b, 1, bp, b == NB - 1);
    add(1, 1, 32'hBAD, 0, 0, 0, 0, 0);           // DONE ignores further beats
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    run_vecs(tag);
    drain(tag);
  endtask

  initial begin
    // ---------------- reset / idle ----------------
    rstn = 1'b0; tvalid = 1'b1; start = 1'b0; tdata = 32'h1234_5678;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      #1;
      check("rst_tready", 256'(tready), 256'(0));
      check("rst_we", 256'(mem_we), 256'(0));
      if (c == 29) begin
        check("rst_addr", 256'(mem_addr), 256'(0));
        check("rst_din", mem_din, 256'(0));
      end
    end
    tvalid = 1'b0;
    rstn   = 1'b1;
    @(negedge clk);
    #1;
    check("idle_tready", 256'(tready), 256'(0));

    // ---------------- full load, continuous ----------------
    full_load("full", 0);
    // ---------------- back-pressure ----------------
    full_load("bp", 1);

    // ---------------- early tlast + re-arm ----------------
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 3, 0, 1, 0, 0, 0);
    for (int j = 0; j < 6; j++) add(1, 1, 32'(1000 + j), j == 5, 1, 1, 3, j);
    add(1, 0, 0, 0, 0, 0, 0, 0);                 // DONE
    add(0, 1, 7, 0, 0, 0, 0, 0);                 // drop arm
    add(1, 1, 9, 0, 0, 0, 0, 0);                 // IDLE, beat not taken
    add(1, 1, 1, 0, 1, 0, 0, 0);                 // ADDR: block 1
    add(1, 1, 2000, 0, 1, 1, 1, 0);
    add(1, 1, 2001, 1, 1, 1, 1, 1);
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    run_vecs("early");
    drain("early");

    // ---------------- out-of-range block ----------------
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add_block(20, 3000, 0, 0, 0);
    add_block(2, 4000, 1, 0, 1);
    add(1, 1, 5, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    run_vecs("oor");
    drain("oor");

    // ---------------- abort mid-block + re-arm ----------------
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 4, 0, 1, 0, 0, 0);
    for (int j = 0; j < 5; j++) add(1, 1, 32'(5000 + j), 0, 1, 1, 4, j);
    add(0, 1, 555, 0, 0, 0, 0, 0);               // tready drops same cycle
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 77, 0, 0, 0, 0, 0);                // IDLE
    add_block(5, 6000, 1, 0, 1);                 // restarts at j=0
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);
    run_vecs("abort");
    drain("abort");

    // ---------------- reset mid-load ----------------
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 6, 0, 1, 0, 0, 0);
    for (int j = 0; j < 3; j++) add(1, 1, 32'(7000 + j), 0, 1, 1, 6, j);
    run_vecs("mrst");
    @(negedge clk);
    tdata = 32'(7003); tvalid = 1'b1; tlast = 1'b0; start = 1'b1;
    #2 rstn = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      check("mrst_tready", 256'(tready), 256'(0));
      check("mrst_we", 256'(mem_we), 256'(0));
    end
    rstn = 1'b1;
    drain("mrst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
